// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: arbitrates the register-file write port between two writeback paths and tracks pending port-1 writes
module regfile_wb_arbiter #(
  parameter int MAX_STARVE = 4
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        p0_valid,
  input  logic [4:0]  p0_addr,
  input  logic [31:0] p0_data,
  output logic        p0_ready,
  input  logic        p1_valid,
  input  logic [4:0]  p1_addr,
  input  logic [31:0] p1_data,
  output logic        p1_ready,
  input  logic        claim_en,
  input  logic [4:0]  claim_addr,
  input  logic [4:0]  qa_addr,
  input  logic [4:0]  qb_addr,
  output logic        qa_busy,
  output logic        qb_busy,
  output logic        wEN,
  output logic [4:0]  w_addr,
  output logic [31:0] busW,
  output logic        sb_err
);
  localparam logic [3:0] maxStarve = 4'(MAX_STARVE);
  logic [31:0] scoreBoard, scoreBoardNext;
  logic [3:0]  starveCnt;
  logic        force1, p0Xfer, p1Xfer, anyXfer;
  logic [4:0]  xferAddr;
  logic [31:0] xferData;
  // grant selection, hazard queries and next scoreboard image
  always_comb begin
    force1 = p1_valid && (starveCnt == maxStarve);
    p1_ready = !clrn && p1_valid && (force1 || !p0_valid);
    p0_ready = !clrn && p0_valid && !p1_ready;
    p0Xfer = p0_valid && p0_ready;
    p1Xfer = p1_valid && p1_ready;
    anyXfer = p0Xfer || p1Xfer;
    xferAddr = p1Xfer ? p1_addr : p0_addr;
    xferData = p1Xfer ? p1_data : p0_data;
    qa_busy = (qa_addr != 5'd0) && scoreBoard[qa_addr];
    qb_busy = (qb_addr != 5'd0) && scoreBoard[qb_addr];
    scoreBoardNext = scoreBoard;
    if (p1Xfer) scoreBoardNext[p1_addr] = 1'b0;
    if (claim_en && claim_addr != 5'd0) scoreBoardNext[claim_addr] = 1'b1;
  end
  // output register, starvation counter, scoreboard and sticky error
  always_ff @(posedge clk) begin
    if (clrn) begin
      wEN <= 1'b0;
      w_addr <= 5'd0;
      busW <= 32'd0;
      sb_err <= 1'b0;
      scoreBoard <= 32'd0;
      starveCnt <= 4'd0;
    end else begin
      wEN <= anyXfer && xferAddr != 5'd0;
      if (anyXfer) begin
        w_addr <= xferAddr;
        busW <= xferData;
      end
      starveCnt <= (!p1_valid || p1Xfer) ? 4'd0 : (p0Xfer && starveCnt != maxStarve) ? starveCnt + 4'd1 : starveCnt;
      scoreBoard <= scoreBoardNext;
      if (p1Xfer && p1_addr != 5'd0 && !scoreBoard[p1_addr]) sb_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed self-checking bench for the writeback arbiter
module tb_regfile_wb_arbiter;
  logic clk = 0, clrn = 1;
  logic p0_valid = 0, p1_valid = 0, claim_en = 0;
  logic [4:0] p0_addr = 0, p1_addr = 0, claim_addr = 0, qa_addr = 0, qb_addr = 0;
  logic [31:0] p0_data = 0, p1_data = 0;
  logic p0_ready, p1_ready, qa_busy, qb_busy, wEN, sb_err;
  logic [4:0] w_addr;
  logic [31:0] busW;
  int nCmp = 0, nErr = 0;

  regfile_wb_arbiter #(.MAX_STARVE(4)) dut (
    .clk(clk), .clrn(clrn),
    .p0_valid(p0_valid), .p0_addr(p0_addr), .p0_data(p0_data), .p0_ready(p0_ready),
    .p1_valid(p1_valid), .p1_addr(p1_addr), .p1_data(p1_data), .p1_ready(p1_ready),
    .claim_en(claim_en), .claim_addr(claim_addr), .qa_addr(qa_addr), .qb_addr(qb_addr),
    .qa_busy(qa_busy), .qb_busy(qb_busy), .wEN(wEN), .w_addr(w_addr), .busW(busW), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCmp++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tick();
    p0_valid = 1; p1_valid = 1;
    #1;
    check("rst_p0_ready", p0_ready, 0);
    check("rst_p1_ready", p1_ready, 0);
    tick();
    clrn = 0; p0_valid = 0; p1_valid = 0;
    #1;
    check("rst_wEN", wEN, 0);
    check("rst_w_addr", w_addr, 0);
    check("rst_busW", busW, 0);
    check("rst_sb_err", sb_err, 0);

    p0_valid = 1; p0_addr = 5; p0_data = 32'hDEADBEEF;
    #1;
    check("p0_ready", p0_ready, 1);
    check("p0_p1_ready", p1_ready, 0);
    tick();
    p0_valid = 0;
    check("p0_wEN", wEN, 1);
    check("p0_w_addr", w_addr, 5);
    check("p0_busW", busW, 32'hDEADBEEF);
    tick();
    check("idle_wEN", wEN, 0);
    check("idle_busW_hold", busW, 32'hDEADBEEF);

    claim_en = 1; claim_addr = 8;
    tick();
    claim_en = 0; qa_addr = 8;
    #1;
    check("claim8_busy", qa_busy, 1);
    p1_valid = 1; p1_addr = 8; p1_data = 32'h3C;
    #1;
    check("p1_ready", p1_ready, 1);
    tick();
    p1_valid = 0;
    #1;
    check("p1_clear_busy", qa_busy, 0);
    check("p1_wEN", wEN, 1);
    check("p1_w_addr", w_addr, 8);
    check("p1_busW", busW, 32'h3C);
    check("p1_sb_err", sb_err, 0);

    claim_en = 1; claim_addr = 10;
    tick();
    claim_en = 0;
    p0_valid = 1; p0_addr = 1; p0_data = 32'h11;
    p1_valid = 1; p1_addr = 10; p1_data = 32'h77;
    for (int i = 0; i < 6; i++) begin
      #1;
      check($sformatf("starve_p0_%0d", i), p0_ready, (i == 4) ? 0 : 1);
      check($sformatf("starve_p1_%0d", i), p1_ready, (i == 4) ? 1 : 0);
      tick();
      check($sformatf("starve_waddr_%0d", i), w_addr, (i == 4) ? 10 : 1);
      if (i == 4) p1_valid = 0;
    end
    p0_valid = 0;
    check("starve_sb_err", sb_err, 0);

    p0_valid = 1; p0_addr = 0; p0_data = 32'hFFFF;
    #1;
    check("r0_p0_ready", p0_ready, 1);
    tick();
    p0_valid = 0;
    check("r0_wEN", wEN, 0);
    claim_en = 1; claim_addr = 0;
    tick();
    claim_en = 0; qa_addr = 0;
    #1;
    check("r0_busy", qa_busy, 0);

    claim_en = 1; claim_addr = 3;
    tick();
    p1_valid = 1; p1_addr = 3; p1_data = 32'h5;
    #1;
    check("race_p1_ready", p1_ready, 1);
    tick();
    claim_en = 0; p1_valid = 0; qa_addr = 3;
    #1;
    check("race_busy", qa_busy, 1);
    check("race_wEN", wEN, 1);
    check("race_sb_err", sb_err, 0);
    p1_valid = 1; p1_addr = 9; p1_data = 32'h9;
    tick();
    p1_valid = 0;
    check("err_set", sb_err, 1);
    tick();
    tick();
    check("err_sticky", sb_err, 1);

    claim_en = 1; claim_addr = 4;
    tick();
    claim_en = 0; qb_addr = 4;
    #1;
    check("r4_busy", qb_busy, 1);
    p1_valid = 1; p1_addr = 4; p1_data = 32'h44; p0_valid = 1; p0_addr = 6;
    clrn = 1;
    #1;
    check("midrst_p1_ready", p1_ready, 0);
    check("midrst_p0_ready", p0_ready, 0);
    tick();
    clrn = 0; p1_valid = 0; p0_valid = 0;
    #1;
    check("midrst_wEN", wEN, 0);
    check("midrst_busW", busW, 0);
    check("midrst_r4_busy", qb_busy, 0);
    check("midrst_r3_busy", qa_busy, 0);
    check("midrst_sb_err", sb_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Owns the single write port of the 32x32 register file.
- Arbitrates that port between two writeback requesters: port 0 is the single-cycle ALU/load path, port 1 is the long-latency multiply/divide unit.
- Keeps a 32-entry pending-write scoreboard so the issue stage can detect RAW hazards on registers awaiting a port-1 result.
- Outputs drive the register file's wEN/w_addr/busW directly, registered on posedge so they are stable at the register file's negedge write.

Parameters:
- MAX_STARVE, 4: consecutive cycles port 1 may wait while port 0 is granted before port 1 is forced through (legal 1..15).

Ports:
- clk  in  1  clock; all state updates on posedge.
- clrn  in  1  reset; synchronous, active-high.
- p0_valid  in  1  port 0 write request.
- p0_addr  in  5  port 0 destination register.
- p0_data  in  32  port 0 write data.
- p0_ready  out  1  port 0 granted this cycle (combinational).
- p1_valid  in  1  port 1 write request.
- p1_addr  in  5  port 1 destination register.
- p1_data  in  32  port 1 write data.
- p1_ready  out  1  port 1 granted this cycle (combinational).
- claim_en  in  1  issue stage marks claim_addr as pending for port 1.
- claim_addr  in  5  register being claimed.
- qa_addr  in  5  hazard query A (decode rs).
- qb_addr  in  5  hazard query B (decode rt).
- qa_busy  out  1  scoreboard[qa_addr] (combinational).
- qb_busy  out  1  scoreboard[qb_addr] (combinational).
- wEN  out  1  register file write enable (registered).
- w_addr  out  5  register file write address (registered).
- busW  out  32  register file write data (registered).
- sb_err  out  1  sticky: port 1 wrote a register that was not pending.

Behaviour:
- Reset (clrn=1 at posedge) dominates every other event:
  - wEN=0, w_addr=0, busW=0, sb_err=0.
  - All 32 scoreboard bits cleared; starve counter=0.
  - While clrn=1, p0_ready=p1_ready=0 and claims are ignored.
- Grant (combinational, at most one per cycle):
  - force1 = p1_valid && (starve_cnt == MAX_STARVE).
  - p1_ready = p1_valid && (force1 || !p0_valid).
  - p0_ready = p0_valid && !p1_ready.
  - A transfer happens on valid && ready. Requesters hold addr/data stable until ready.
- Starve counter (4 bits):
  - Increments when p1_valid && p0 transfers; saturates at MAX_STARVE.
  - Clears on a p1 transfer or whenever p1_valid=0.
- Output register, 1-cycle latency:
  - If a transfer happens in cycle T, then in cycle T+1: wEN=1, w_addr=granted addr, busW=granted data.
  - With no transfer in cycle T, wEN=0 in T+1 and w_addr/busW hold their previous values.
- Register 0:
  - A transfer to addr 0 is accepted (ready asserted) but wEN stays 0 in T+1.
  - Claims of addr 0 are ignored; qa_busy/qb_busy for addr 0 are always 0.
- Scoreboard:
  - claim_en sets bit[claim_addr] at posedge.
  - A p1 transfer clears bit[p1_addr] at posedge.
  - If claim and p1 clear target the same addr in the same cycle, the claim wins and the bit stays 1.
  - A p0 transfer never touches the scoreboard.
  - Re-claiming a bit that is already 1 is harmless.
- Hazard timing:
  - The bit clears at posedge T+1, and the register file writes at negedge T+1.
  - A reader that sees busy=0 in cycle T+1 reads after that negedge and gets the new value; no extra bypass is required.
- sb_err is set at posedge when a p1 transfer has p1_addr!=0 and its scoreboard bit is 0. It is cleared only by reset.
- Mid-operation reset: any grant in the reset cycle is discarded, and the output register shows wEN=0 on the following cycle.

Test Plan:
- Reset, then p0 writes r5=32'hDEADBEEF → p0_ready=1 in same cycle; next cycle wEN=1, w_addr=5, busW=32'hDEADBEEF; following cycle wEN=0.
- claim r8; query qa_addr=8 → qa_busy=1. p1 writes r8=32'h3C → p1_ready=1; next cycle qa_busy=0, wEN=1, w_addr=8; sb_err stays 0.
- p0_valid held high continuously with p1_valid high (MAX_STARVE=4) → p0 granted 4 cycles, p1 granted on cycle 5, counter returns to 0, then p0 resumes.
- p0 writes r0=32'hFFFF → p0_ready=1, wEN stays 0; claim r0 → qa_busy(0)=0.
- Same cycle: claim r3 and p1 transfer to r3 (previously claimed) → bit stays 1, qa_busy(3)=1. Then p1 writes unclaimed r9 → sb_err=1 and stays 1 until reset.
- Assert clrn during a p1 transfer with r4 pending → no write next cycle, all busy bits 0, sb_err=0, readies 0 while clrn=1.
